// File: rtl/adder_arbiter.sv
// adder_arbiter: two requesters share one WIDTH-bit adder under a
// round-robin grant; results are presented on a valid/ready port.
module adder_arbiter #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_id,
  output logic [7:0]       carry_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             last;
  logic             win;
  logic             any_req;
  logic             accept;
  logic             gnt0_d;
  logic             gnt1_d;
  logic             valid_d;
  logic             cnt_inc;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   sum;

  assign any_req = req0 | req1;
  assign accept  = out_valid & out_ready;
  assign sum     = {1'b0, op_a} + {1'b0, op_b};

  // last holds the index granted most recently; a tie goes to the other one
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (req0 & req1):  win = ~last;
      (req1 & ~req0): win = 1'b1;
      default:        win = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = COMPUTE;
      COMPUTE: state_nx = HOLD;
      HOLD:    if (accept) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // out_valid rises one cycle into HOLD, so the first HOLD cycle marks the rise
  always_comb begin
    gnt0_d  = (state == IDLE) & any_req & ~win;
    gnt1_d  = (state == IDLE) & any_req & win;
    valid_d = (state == HOLD) & ~accept;
    cnt_inc = (state == HOLD) & ~out_valid & out_carry
            & (carry_cnt != 8'hFF);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_id    <= 1'b0;
      carry_cnt <= 8'd0;
      last      <= 1'b1;
      op_a      <= '0;
      op_b      <= '0;
    end else begin
      gnt0      <= gnt0_d;
      gnt1      <= gnt1_d;
      out_valid <= valid_d;
      if (gnt0_d | gnt1_d) begin
        op_a   <= win ? a1 : a0;
        op_b   <= win ? b1 : b0;
        out_id <= win;
        last   <= win;
      end
      if (state == COMPUTE) begin
        {out_carry, out_sum} <= sum;
      end
      if (cnt_inc) begin
        carry_cnt <= carry_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed vector table plus hand-written sequences
// for stall, round-robin, saturation and mid-transaction reset.
module tb_adder_arbiter;

  logic       clk;
  logic       reset_n;
  logic       req0;
  logic [8:0] a0;
  logic [8:0] b0;
  logic       gnt0;
  logic       req1;
  logic [8:0] a1;
  logic [8:0] b1;
  logic       gnt1;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_sum;
  logic       out_carry;
  logic       out_id;
  logic [7:0] carry_cnt;

  adder_arbiter #(.WIDTH(9)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry),
    .out_id(out_id), .carry_cnt(carry_cnt)
  );

  typedef struct {
    logic       r0;
    logic [8:0] x0;
    logic [8:0] y0;
    logic       r1;
    logic [8:0] x1;
    logic [8:0] y1;
    logic       id;
    logic [8:0] sum;
    logic       cy;
  } vec_t;

  vec_t tv [8];
  int   n_chk;
  int   n_err;
  int   exp_cnt;
  logic exp_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic bump(input logic cy);
    if (cy && exp_cnt < 255) exp_cnt++;
  endtask

  task automatic wait_gnt(output bit got);
    got = 1'b0;
    for (int t = 0; t < 8 && !got; t++) begin
      @(negedge clk);
      got = gnt0 | gnt1;
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    bit got;
    req0 = v.r0; a0 = v.x0; b0 = v.y0;
    req1 = v.r1; a1 = v.x1; b1 = v.y1;
    out_ready = 1'b1;
    wait_gnt(got);
    chk({nm, " gnt"}, {gnt1, gnt0}, v.id ? 2'b10 : 2'b01);
    req0 = 1'b0; req1 = 1'b0;
    a0 = ~v.x0; b0 = ~v.y0; a1 = ~v.x1; b1 = ~v.y1;
    @(negedge clk);
    chk({nm, " early valid"}, out_valid, 1'b0);
    @(negedge clk);
    chk({nm, " valid"}, out_valid, 1'b1);
    chk({nm, " sum"}, out_sum, v.sum);
    chk({nm, " carry"}, out_carry, v.cy);
    chk({nm, " id"}, out_id, v.id);
    bump(v.cy);
    chk({nm, " cnt"}, carry_cnt, exp_cnt);
    @(negedge clk);
    chk({nm, " valid drop"}, out_valid, 1'b0);
    exp_last = v.id;
  endtask

  initial begin
    bit   got;
    int   ng;
    int   last_t;
    logic exp_w;
    logic pend;
    vec_t v;

    tv[0] = '{1'b1, 9'h100, 9'h001, 1'b0, 9'h000, 9'h000, 1'b0, 9'h101, 1'b0};
    tv[1] = '{1'b0, 9'h000, 9'h000, 1'b1, 9'h100, 9'h100, 1'b1, 9'h000, 1'b1};
    tv[2] = '{1'b1, 9'h1FF, 9'h1FF, 1'b1, 9'h001, 9'h002, 1'b0, 9'h1FE, 1'b1};
    tv[3] = '{1'b1, 9'h003, 9'h004, 1'b1, 9'h0FF, 9'h001, 1'b1, 9'h100, 1'b0};
    tv[4] = '{1'b1, 9'h000, 9'h000, 1'b0, 9'h000, 9'h000, 1'b0, 9'h000, 1'b0};
    tv[5] = '{1'b1, 9'h1FF, 9'h001, 1'b0, 9'h000, 9'h000, 1'b0, 9'h000, 1'b1};
    tv[6] = '{1'b1, 9'h055, 9'h0AA, 1'b1, 9'h100, 9'h0FF, 1'b1, 9'h1FF, 1'b0};
    tv[7] = '{1'b0, 9'h000, 9'h000, 1'b1, 9'h1FF, 9'h1FF, 1'b1, 9'h1FE, 1'b1};

    n_chk = 0; n_err = 0; exp_cnt = 0; exp_last = 1'b1;

    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req0 = 1'($urandom); a0 = 9'($urandom); b0 = 9'($urandom);
      req1 = 1'($urandom); a1 = 9'($urandom); b1 = 9'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      chk("reset outputs",
          {gnt0, gnt1, out_valid, out_carry, out_id, out_sum, carry_cnt}, 0);
    end
    req0 = 1'b0; req1 = 1'b0; out_ready = 1'b1;
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec(tv[i], $sformatf("vec%0d", i));
    end

    // back-pressure: result held, pending req1 must wait
    req0 = 1'b1; a0 = 9'h1FF; b0 = 9'h1FF; out_ready = 1'b0;
    wait_gnt(got);
    chk("stall gnt0", {gnt1, gnt0}, 2'b01);
    req0 = 1'b0; req1 = 1'b1; a1 = 9'h0AB; b1 = 9'h011;
    @(negedge clk);
    bump(1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall valid", out_valid, 1'b1);
      chk("stall data", {out_carry, out_sum}, 10'h3FE);
      chk("stall no gnt1", gnt1, 1'b0);
    end
    chk("stall cnt", carry_cnt, exp_cnt);
    out_ready = 1'b1;
    @(negedge clk);
    chk("accept valid drop", out_valid, 1'b0);
    chk("accept no gnt yet", gnt1, 1'b0);
    @(negedge clk);
    chk("gnt1 after accept", gnt1, 1'b1);
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("pend1 result", {out_valid, out_id, out_carry, out_sum},
        {1'b1, 1'b1, 1'b0, 9'h0BC});
    exp_last = 1'b1;
    @(negedge clk);

    // both held: strict alternation, one grant every 4 cycles
    req0 = 1'b1; a0 = 9'h010; b0 = 9'h020;
    req1 = 1'b1; a1 = 9'h1F0; b1 = 9'h020;
    exp_w = ~exp_last; ng = 0; last_t = 0; pend = 1'b0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("rr id", out_id, pend);
        chk("rr data", {out_carry, out_sum}, pend ? 10'h210 : 10'h030);
        bump(pend);
        chk("rr cnt", carry_cnt, exp_cnt);
      end
      if (gnt0 | gnt1) begin
        chk("rr gnt", {gnt1, gnt0}, exp_w ? 2'b10 : 2'b01);
        if (ng > 0) chk("rr spacing", c - last_t, 4);
        last_t = c; pend = exp_w; exp_w = ~exp_w; ng++;
      end
    end
    chk("rr grants", ng, 4);
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rr last valid", {out_valid, out_id}, {1'b1, pend});
    bump(pend);
    chk("rr last cnt", carry_cnt, exp_cnt);
    @(negedge clk);

    // carry counter saturates at 255
    req1 = 1'b1; a1 = 9'h100; b1 = 9'h100; out_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 2000 && ng < 260; c++) begin
      @(negedge clk);
      if (gnt1) begin
        ng++;
        bump(1'b1);
      end
    end
    req1 = 1'b0;
    chk("sat grants", ng, 260);
    repeat (4) @(negedge clk);
    chk("sat cnt", carry_cnt, exp_cnt);

    // reset pulsed while the transaction is in COMPUTE
    req0 = 1'b1; a0 = 9'h1FF; b0 = 9'h001;
    wait_gnt(got);
    chk("rst gnt0", {gnt1, gnt0}, 2'b01);
    req0 = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst immediate",
        {gnt0, gnt1, out_valid, out_carry, out_id, out_sum, carry_cnt}, 0);
    #1;
    reset_n = 1'b1;
    exp_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rst no valid", out_valid, 1'b0);
    end
    chk("rst cnt", carry_cnt, 8'd0);

    v = '{1'b1, 9'h0F0, 9'h00F, 1'b1, 9'h001, 9'h001, 1'b0, 9'h0FF, 1'b0};
    run_vec(v, "post-rst rr");

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: WIDTH, 9, operand/sum width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req0  input  1  requester 0 requests an add.
REQ-005 a0, b0  input  WIDTH each  requester 0 operands.
REQ-006 gnt0  output  1  one-cycle pulse; requester 0 operands sampled this cycle.
REQ-007 req1  input  1  requester 1 requests an add.
REQ-008 a1, b1  input  WIDTH each  requester 1 operands.
REQ-009 gnt1  output  1  one-cycle pulse; requester 1 operands sampled this cycle.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_sum  output  WIDTH  low WIDTH bits of the sum.
REQ-013 out_carry  output  1  carry-out of the sum.
REQ-014 out_id  output  1  requester index of the result.
REQ-015 carry_cnt  output  8  saturating count of results with out_carry=1.

Function
REQ-016 Block SHALL time-share one WIDTH-bit adder between two requesters via FSM states IDLE, COMPUTE, HOLD.
REQ-017 IDLE: no request -> stay; any req -> assert exactly one gnt, latch that requester's operands and index, go COMPUTE.
REQ-018 Arbitration SHALL be round-robin: single requester wins; both requesting -> the one not granted last wins; pointer after reset favours requester 0.
REQ-019 COMPUTE (one cycle): register {out_carry, out_sum} = a + b of latched operands, zero-extended to WIDTH+1 bits, no truncation of carry; set out_valid; go HOLD.
REQ-020 Latency: gnt pulse in cycle T -> out_valid first high in cycle T+2.
REQ-021 HOLD: out_valid high; out_sum, out_carry, out_id stable until out_valid && out_ready; then out_valid low next cycle, go IDLE.
REQ-022 No gnt SHALL be issued in COMPUTE or HOLD; pending requests wait; max one transaction in flight.
REQ-023 Requester holds req and operands until its gnt; deasserting req before gnt withdraws it without side effect; operand changes after gnt have no effect.
REQ-024 carry_cnt SHALL increment by 1 in the cycle out_valid rises if the new out_carry=1; saturate at 255, no wrap.
REQ-025 gnt0 and gnt1 SHALL never be high together; outputs SHALL be registered.
REQ-026 Both operands all-ones: out_sum = all-ones minus 1, out_carry=1.

Reset
REQ-027 reset_n low SHALL immediately force: state IDLE, gnt0=gnt1=0, out_valid=0, out_sum=0, out_carry=0, out_id=0, carry_cnt=0, round-robin pointer favouring requester 0.
REQ-028 Reset during COMPUTE or HOLD SHALL discard the transaction; no out_valid results from it after release.
REQ-029 First rising edge after reset_n rises SHALL behave as IDLE.

Verification
REQ-030 reset_n low 3 cycles, random inputs -> all outputs 0 throughout; no gnt.
REQ-031 req0=1, a0=0x100, b0=0x001, out_ready=1 -> gnt0 at T, out_valid at T+2, out_sum=0x101, out_carry=0, out_id=0, carry_cnt=0.
REQ-032 req1=1, a1=0x100, b1=0x100 -> out_sum=0x000, out_carry=1, out_id=1, carry_cnt=1; repeat 260 times -> carry_cnt=255.
REQ-033 req0=req1=1 held, out_ready=1 -> grant order 0,1,0,1; each out_id matches; one gnt per 4 cycles.
REQ-034 out_ready=0 for 5 cycles with req1 pending -> out_valid and data stable, no gnt1; out_ready=1 -> gnt1 two cycles after acceptance.
REQ-035 reset_n pulsed low in COMPUTE cycle -> out_valid never rises for that transaction; carry_cnt=0.
